// File: rtl/branch_resolution_controller.sv
// In-flight branch tracker: allocates slots at dispatch, captures resolved outcomes,
// retires in program order and raises predictor update / flush / redirect on retirement.
module branch_resolution_controller #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TW    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          dispatch_valid,
    output logic          dispatch_ready,
    input  logic          dispatch_predicted,
    input  logic [31:0]   dispatch_pc,
    input  logic [31:0]   dispatch_target,
    output logic [TW-1:0] dispatch_tag,
    input  logic          resolve_valid,
    input  logic [TW-1:0] resolve_tag,
    input  logic          resolve_taken,
    input  logic          commit_req,
    output logic          commit_ack,
    output logic          upd_valid,
    output logic          upd_wrong,
    output logic          flush,
    output logic [31:0]   redirect_pc,
    output logic [TW:0]   count
);

    localparam int unsigned CW = TW + 1;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [DEPTH-1:0]   valid_q, valid_d;
    logic [DEPTH-1:0]   resolved_q, resolved_d;
    logic [DEPTH-1:0]   pred_q, pred_d;
    logic [DEPTH-1:0]   taken_q, taken_d;
    logic [31:0]        pc_q [DEPTH];
    logic [31:0]        pc_d [DEPTH];
    logic [31:0]        target_q [DEPTH];
    logic [31:0]        target_d [DEPTH];
    logic [TW-1:0]      head_q, head_d;
    logic [TW-1:0]      tail_q, tail_d;
    logic [CW-1:0]      count_q, count_d;
    logic               upd_valid_q, upd_valid_d;
    logic               upd_wrong_q, upd_wrong_d;
    logic               flush_q, flush_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;

    logic               dispatch_fire_c;
    logic               wrong_c;
    logic               mispredict_c;

    assign dispatch_ready  = (count_q < CW'(DEPTH)) && (state_q == ST_RUN);
    assign commit_ack      = commit_req && (state_q == ST_RUN)
                             && valid_q[head_q] && resolved_q[head_q];
    assign dispatch_fire_c = dispatch_valid && dispatch_ready;
    assign wrong_c         = pred_q[head_q] != taken_q[head_q];
    assign mispredict_c    = commit_ack && wrong_c;

    assign dispatch_tag = tail_q;
    assign count        = count_q;
    assign upd_valid    = upd_valid_q;
    assign upd_wrong    = upd_wrong_q;
    assign flush        = flush_q;
    assign redirect_pc  = redirect_pc_q;

    // Next-state: dispatch write, resolve capture, commit retire, mispredict squash
    always_comb begin
        state_d       = state_q;
        valid_d       = valid_q;
        resolved_d    = resolved_q;
        pred_d        = pred_q;
        taken_d       = taken_q;
        pc_d          = pc_q;
        target_d      = target_q;
        head_d        = head_q;
        tail_d        = tail_q;
        count_d       = count_q + CW'(dispatch_fire_c) - CW'(commit_ack);
        upd_valid_d   = commit_ack;
        upd_wrong_d   = mispredict_c;
        flush_d       = mispredict_c;
        redirect_pc_d = '0;

        case (state_q)
            ST_RUN:   if (mispredict_c) state_d = ST_FLUSH;
            ST_FLUSH: state_d = ST_RUN;
            default:  state_d = ST_RUN;
        endcase

        if (dispatch_fire_c) begin
            valid_d[tail_q]    = 1'b1;
            resolved_d[tail_q] = 1'b0;
            pred_d[tail_q]     = dispatch_predicted;
            pc_d[tail_q]       = dispatch_pc;
            target_d[tail_q]   = dispatch_target;
            tail_d             = tail_q + TW'(1);
        end

        if (resolve_valid && (state_q == ST_RUN) && valid_q[resolve_tag]) begin
            resolved_d[resolve_tag] = 1'b1;
            taken_d[resolve_tag]    = resolve_taken;
        end

        if (commit_ack) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + TW'(1);
        end

        // A mispredicted retirement squashes everything younger, including a same-cycle dispatch
        if (mispredict_c) begin
            redirect_pc_d = taken_q[head_q] ? target_q[head_q] : pc_q[head_q] + 32'd4;
            valid_d       = '0;
            resolved_d    = '0;
            head_d        = '0;
            tail_d        = '0;
            count_d       = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_RUN;
            valid_q       <= '0;
            resolved_q    <= '0;
            pred_q        <= '0;
            taken_q       <= '0;
            head_q        <= '0;
            tail_q        <= '0;
            count_q       <= '0;
            upd_valid_q   <= 1'b0;
            upd_wrong_q   <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pc_q[i]     <= '0;
                target_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            valid_q       <= valid_d;
            resolved_q    <= resolved_d;
            pred_q        <= pred_d;
            taken_q       <= taken_d;
            head_q        <= head_d;
            tail_q        <= tail_d;
            count_q       <= count_d;
            upd_valid_q   <= upd_valid_d;
            upd_wrong_q   <= upd_wrong_d;
            flush_q       <= flush_d;
            redirect_pc_q <= redirect_pc_d;
            pc_q          <= pc_d;
            target_q      <= target_d;
        end
    end

endmodule

// File: tb/tb_branch_resolution_controller.sv
// Bench for branch_resolution_controller: directed sequences plus random traffic checked
// against an in-order queue model of the in-flight branches.
module tb_branch_resolution_controller;

    localparam int DEPTH = 4;
    localparam int TW    = 2;

    logic          clk;
    logic          rst;
    logic          dispatch_valid;
    logic          dispatch_ready;
    logic          dispatch_predicted;
    logic [31:0]   dispatch_pc;
    logic [31:0]   dispatch_target;
    logic [TW-1:0] dispatch_tag;
    logic          resolve_valid;
    logic [TW-1:0] resolve_tag;
    logic          resolve_taken;
    logic          commit_req;
    logic          commit_ack;
    logic          upd_valid;
    logic          upd_wrong;
    logic          flush;
    logic [31:0]   redirect_pc;
    logic [TW:0]   count;

    branch_resolution_controller #(.DEPTH(DEPTH), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_predicted(dispatch_predicted), .dispatch_pc(dispatch_pc),
        .dispatch_target(dispatch_target), .dispatch_tag(dispatch_tag),
        .resolve_valid(resolve_valid), .resolve_tag(resolve_tag),
        .resolve_taken(resolve_taken), .commit_req(commit_req),
        .commit_ack(commit_ack), .upd_valid(upd_valid), .upd_wrong(upd_wrong),
        .flush(flush), .redirect_pc(redirect_pc), .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          tag;
        bit          pred;
        bit          taken;
        bit          resolved;
        logic [31:0] pc;
        logic [31:0] tgt;
    } ent_t;

    // Model: program-ordered queue of in-flight branches plus expected registered outputs
    ent_t        mq[$];
    int          m_tag;
    bit          m_flush;
    bit          e_uv, e_uw, e_fl;
    logic [31:0] e_rpc;
    int          n_checks;
    int          n_pass;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit m_ready();
        return (mq.size() < DEPTH) && !m_flush;
    endfunction

    function automatic bit m_ack();
        return commit_req && !m_flush && (mq.size() > 0) && mq[0].resolved;
    endfunction

    task automatic check_outputs();
        chk("dispatch_ready", 32'(dispatch_ready), 32'(m_ready()));
        chk("dispatch_tag",   32'(dispatch_tag),   32'(m_tag));
        chk("commit_ack",     32'(commit_ack),     32'(m_ack()));
        chk("count",          32'(count),          32'(mq.size()));
        chk("upd_valid",      32'(upd_valid),      32'(e_uv));
        chk("upd_wrong",      32'(upd_wrong),      32'(e_uw));
        chk("flush",          32'(flush),          32'(e_fl));
        if (e_fl) chk("redirect_pc", redirect_pc, e_rpc);
    endtask

    task automatic model_update();
        bit   ready, ack, wrong;
        ent_t h;
        ready = m_ready();
        ack   = m_ack();
        wrong = 1'b0;
        e_rpc = '0;
        if (ack) begin
            h     = mq[0];
            wrong = (h.pred != h.taken);
            if (wrong) e_rpc = h.taken ? h.tgt : h.pc + 32'd4;
        end
        e_uv = ack;
        e_uw = wrong;
        e_fl = wrong;
        if (resolve_valid && !m_flush) begin
            foreach (mq[i]) begin
                if (mq[i].tag == int'(resolve_tag)) begin
                    mq[i].resolved = 1'b1;
                    mq[i].taken    = resolve_taken;
                end
            end
        end
        if (wrong) begin
            mq.delete();
            m_tag   = 0;
            m_flush = 1'b1;
        end else begin
            m_flush = 1'b0;
            if (ack) void'(mq.pop_front());
            if (dispatch_valid && ready) begin
                mq.push_back('{tag: m_tag, pred: dispatch_predicted, taken: 1'b0,
                               resolved: 1'b0, pc: dispatch_pc, tgt: dispatch_target});
                m_tag = (m_tag + 1) % DEPTH;
            end
        end
    endtask

    // One cycle: drive at posedge+1, compare at negedge, advance model to the next edge
    task automatic step(input bit dv, input bit pr, input logic [31:0] pc, input logic [31:0] tgt,
                        input bit rv, input int rt, input bit rtk, input bit cr);
        dispatch_valid     = dv;
        dispatch_predicted = pr;
        dispatch_pc        = pc;
        dispatch_target    = tgt;
        resolve_valid      = rv;
        resolve_tag        = TW'(rt);
        resolve_taken      = rtk;
        commit_req         = cr;
        @(negedge clk);
        check_outputs();
        model_update();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst                = 1'b1;
        dispatch_valid     = 1'b0;
        dispatch_predicted = 1'b0;
        dispatch_pc        = '0;
        dispatch_target    = '0;
        resolve_valid      = 1'b0;
        resolve_tag        = '0;
        resolve_taken      = 1'b0;
        commit_req         = 1'b0;
        mq.delete();
        m_tag   = 0;
        m_flush = 1'b0;
        e_uv    = 1'b0;
        e_uw    = 1'b0;
        e_fl    = 1'b0;
        e_rpc   = '0;
        #1;
        check_outputs();
        chk("reset_redirect_pc", redirect_pc, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        do_reset();

        // Fill to DEPTH, then a commit and a dispatch in the same cycle: dispatch refused
        for (int i = 0; i < DEPTH; i++) step(1, 1, 32'h100 + 32'(16 * i), 32'h800 + 32'(16 * i), 0, 0, 0, 0);
        chk("full_count", 32'(count), 32'd4);
        chk("full_ready", 32'(dispatch_ready), 32'd0);
        step(0, 0, 0, 0, 1, 0, 1, 0);
        step(1, 0, 32'h900, 32'h990, 1, 1, 1, 1);
        chk("refused_count", 32'(count), 32'd3);
        step(0, 0, 0, 0, 1, 2, 1, 1);
        step(0, 0, 0, 0, 1, 3, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("drained_count", 32'(count), 32'd0);

        // Mispredict with two younger branches in flight and a resolve during FLUSH
        do_reset();
        step(1, 1, 32'h100, 32'h200, 0, 0, 0, 0);
        step(1, 0, 32'h300, 32'h400, 0, 0, 0, 0);
        step(1, 0, 32'h500, 32'h600, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("mp_flush", 32'(flush), 32'd1);
        chk("mp_redirect", redirect_pc, 32'h104);
        chk("mp_count", 32'(count), 32'd0);
        chk("mp_ready", 32'(dispatch_ready), 32'd0);
        step(1, 0, 32'h700, 32'h780, 1, 2, 1, 1);
        chk("post_flush_tag", 32'(dispatch_tag), 32'd0);
        chk("post_flush_ready", 32'(dispatch_ready), 32'd1);
        step(1, 0, 32'h700, 32'h780, 0, 0, 0, 0);

        // Out-of-order resolve: head blocks retirement until it resolves
        do_reset();
        step(1, 0, 32'h40, 32'h80, 0, 0, 0, 0);
        step(1, 1, 32'h44, 32'h88, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 1, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Random traffic with occasional mid-stream resets
        for (int n = 0; n < 3000; n++) begin
            int          rt;
            bit          rtk;
            logic [31:0] pc;
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                rt  = int'($urandom_range(0, DEPTH - 1));
                rtk = 1'($urandom);
                foreach (mq[i]) if (mq[i].tag == rt) rtk = ($urandom_range(0, 3) == 0) ? !mq[i].pred : mq[i].pred;
                pc  = $urandom & 32'hFFFF_FFFC;
                step($urandom_range(0, 9) < 6, 1'($urandom), pc, $urandom & 32'hFFFF_FFFC,
                     $urandom_range(0, 1) == 1, rt, rtk, $urandom_range(0, 9) < 6);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/branch_resolution_controller.md
# branch_resolution_controller

In-flight branch tracker and commit sequencer for the out-of-order core. It allocates a slot for every dispatched `beq`/`bne` and records the direction predicted by the branch predictor. It captures resolved outcomes from the execute stage, retires branches in program order when the ROB head requests it, and generates the predictor update, the pipeline flush and the redirect PC on a misprediction.

## Interface

Parameters:
- `DEPTH`, 4: number of in-flight branch slots; power of two, 2..16.
- `TW`, 2: tag width, equal to log2(`DEPTH`).

Ports:
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `dispatch_valid`  in  1  a branch is dispatched this cycle.
- `dispatch_ready`  out  1  a slot is free and the controller is in RUN.
- `dispatch_predicted`  in  1  predicted direction, 1 = taken.
- `dispatch_pc`  in  32  branch PC.
- `dispatch_target`  in  32  taken-path target address.
- `dispatch_tag`  out  TW  slot index to be allocated; equals the tail pointer.
- `resolve_valid`  in  1  execute stage resolved a branch.
- `resolve_tag`  in  TW  slot being resolved.
- `resolve_taken`  in  1  actual direction.
- `commit_req`  in  1  ROB head is a branch awaiting retirement.
- `commit_ack`  out  1  head branch retires this cycle (combinational).
- `upd_valid`  out  1  predictor update strobe; registered, 1 cycle.
- `upd_wrong`  out  1  retired branch was mispredicted; qualified by `upd_valid`.
- `flush`  out  1  squash all younger instructions; registered, 1 cycle.
- `redirect_pc`  out  32  fetch restart address; valid while `flush`=1.
- `count`  out  TW+1  number of occupied slots.

## Operation

Per-slot storage: `valid`, `resolved`, `pred`, `taken`, `pc[31:0]`, `target[31:0]`. Pointers are `head` and `tail`, each TW bits with modulo-`DEPTH` wrap-around. `count` is held as a separate register.

FSM with two states:
- RUN: normal operation.
- FLUSH: entered for exactly one cycle after a mispredicted retirement, then returns to RUN.

Dispatch:
- A dispatch fires on `dispatch_valid && dispatch_ready`.
- `dispatch_ready` = (`count` < `DEPTH`) && state==RUN. It does not depend on a same-cycle commit, so there is no bypass when full.
- On fire, write the slot at `tail` with `valid`=1 and `resolved`=0, then increment `tail`.

Resolve:
- When `resolve_valid`=1 in RUN and the slot at `resolve_tag` is valid, set `resolved` and `taken` for that slot.
- A resolve to an invalid slot is ignored.
- A resolve received in FLUSH is ignored.
- A second resolve to the same slot overwrites `taken`.

Commit:
- `commit_ack` = `commit_req` && state==RUN && `valid[head]` && `resolved[head]`.
- On ack, clear `valid[head]` and increment `head`.
- Mispredict condition: `wrong` = `pred[head]` != `taken[head]`.
- Next cycle: `upd_valid`=1 and `upd_wrong`=`wrong`.
- If `wrong`:
  - next cycle `flush`=1;
  - `redirect_pc` = `taken ? target : pc + 4`, with the addition modulo 2^32;
  - state goes to FLUSH;
  - at the ack edge, all slots are invalidated, `head`=`tail`=0 and `count`=0. Every younger branch is squashed.

Count arithmetic:
- `count` next = `count` + dispatch_fire − commit_ack.
- A dispatch in the same cycle as a mispredicted ack is discarded: the flush wins and `count` becomes 0.

Reset values: all slots invalid, `head`=`tail`=0, `count`=0, state RUN, and `dispatch_ready`=1 (count is 0). `commit_ack`, `upd_valid`, `upd_wrong` and `flush` are 0. `redirect_pc`=0 and `dispatch_tag`=0. A reset mid-operation abandons all entries immediately.

## Timing

- Dispatch to visible: the slot is written at edge N, and `count` updates at edge N.
- A resolve at edge N enables `commit_ack` from cycle N+1 onward. The earliest retirement is 1 cycle after resolve.
- Ack in cycle N: `upd_valid`, `upd_wrong`, `flush` and `redirect_pc` are valid in cycle N+1, each high for exactly 1 cycle.
- Misprediction recovery:
  - `dispatch_ready`=0 and `commit_ack`=0 in cycle N+1 (FLUSH);
  - dispatch resumes in cycle N+2.
- Correctly predicted retirements may be acked back-to-back, one per cycle.
- Wrap-around: tags reuse slots cyclically, so after `DEPTH` allocations `dispatch_tag` returns to 0.

## Test plan

- Reset, then dispatch 4 branches (DEPTH=4) -> tags 0,1,2,3; `count`=4; `dispatch_ready`=0. Commit and dispatch in the same cycle -> the dispatch is refused.
- Dispatch tag 0 with pred=1, resolve taken=1, assert `commit_req` -> `commit_ack` in the cycle after the resolve. Next cycle `upd_valid`=1, `upd_wrong`=0, `flush`=0.
- Dispatch pc=0x100, target=0x200, pred=1; resolve taken=0; commit -> `flush`=1 and `redirect_pc`=0x104 for 1 cycle. `count`=0; `dispatch_ready`=0 for 1 cycle, then 1.
- Dispatch tags 0,1; resolve tag 1 only; `commit_req`=1 -> no ack until tag 0 is resolved, then tags 0 and 1 ack on consecutive cycles.
- Mispredict on tag 0 with tags 1 and 2 in flight, and a resolve to tag 2 during FLUSH -> tags 1 and 2 are discarded and the resolve is ignored. The next dispatch receives tag 0.
- Fill, then drain 6 times with `rst` pulsed mid-stream -> pointers wrap correctly, and after reset `count`=0 and every output is at its reset value.
